// File: rtl/demux_rr_sched_if.sv
// Handshake bundle for the round-robin 1:4 demux scheduler.
// master: producer/consumer side; slave: the scheduler itself.
interface demux_rr_sched_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned CW = 16
);
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    en_mask;
    logic [DW-1:0] out_data;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;
    logic [1:0]    sel;
    logic          busy;
    logic [CW-1:0] sent_cnt;

    modport master (
        output in_data, in_valid, en_mask, out_ready,
        input  in_ready, out_data, out_valid, sel, busy, sent_cnt
    );

    modport slave (
        input  in_data, in_valid, en_mask, out_ready,
        output in_ready, out_data, out_valid, sel, busy, sent_cnt
    );
endinterface

// File: rtl/demux_rr_sched.sv
// Round-robin scheduler: one-entry buffer feeding four channels over a shared
// data bus with a 2-bit select and per-channel valid/ready.
module demux_rr_sched #(
    parameter int unsigned DW = 8,
    parameter int unsigned CW = 16
) (
    input logic             clk,
    input logic             rst_n,
    demux_rr_sched_if.slave bus
);
    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] data_q, data_d;
    logic [3:0]    valid_q, valid_d;
    logic [1:0]    sel_q, sel_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          deliver;
    logic          accept;
    logic          in_ready;
    logic [1:0]    base;
    logic [1:0]    pick;

    // Handshake decode; in_ready is forced low while reset is asserted
    always_comb begin
        deliver  = (state_q == StHold) && bus.out_ready[sel_q];
        in_ready = rst_n && (|bus.en_mask) &&
                   ((state_q == StIdle) || bus.out_ready[sel_q]);
        accept   = bus.in_valid && in_ready;
    end

    // Pick the first enabled channel at or after the pointer; on a same-cycle
    // delivery the search starts just past the channel being delivered
    always_comb begin
        base = deliver ? (sel_q + 2'd1) : ptr_q;
        pick = base;
        for (int i = 3; i >= 0; i--) begin
            if (bus.en_mask[base + 2'(i)]) begin
                pick = base + 2'(i);
            end
        end
    end

    // Next-state: delivery retires the word, an accept (possibly the same cycle) loads a new one
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        valid_d = valid_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (deliver) begin
            cnt_d   = cnt_q + CW'(1);
            ptr_d   = sel_q + 2'd1;
            state_d = StIdle;
            valid_d = 4'b0000;
        end
        if (accept) begin
            data_d  = bus.in_data;
            sel_d   = pick;
            valid_d = 4'b0001 << pick;
            state_d = StHold;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            data_q  <= '0;
            valid_q <= 4'b0000;
            sel_q   <= 2'b00;
            ptr_q   <= 2'b00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.sel       = sel_q;
    assign bus.busy      = (state_q == StHold);
    assign bus.sent_cnt  = cnt_q;
endmodule

// File: tb/tb_demux_rr_sched.sv
// Self-checking bench for demux_rr_sched: directed scenarios plus a random run
// against a transaction-level model (held word, channel, pointer, count).
module tb_demux_rr_sched;
    localparam int DW = 8;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    demux_rr_sched_if #(.DW(DW), .CW(CW)) bus ();

    demux_rr_sched #(.DW(DW), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model
    bit            m_held;
    logic [DW-1:0] m_data;
    int            m_ch;
    int            m_ptr;
    logic [CW-1:0] m_cnt;

    task automatic model_reset();
        m_held = 0; m_data = '0; m_ch = 0; m_ptr = 0; m_cnt = '0;
    endtask

    function automatic logic m_in_ready();
        return rst_n && (bus.en_mask != 4'b0000) && (!m_held || bus.out_ready[m_ch]);
    endfunction

    function automatic logic [3:0] m_valid();
        return m_held ? (4'b0001 << m_ch) : 4'b0000;
    endfunction

    // Apply inputs shortly after a rising edge
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [3:0] en,
                         input logic [3:0] rdy);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.en_mask   = en;
        bus.out_ready = rdy;
        #2;
    endtask

    // Advance one edge and apply the transfer rules to the model
    task automatic tick();
        logic dlv, acc;
        bit   found;
        @(posedge clk);
        dlv = m_held && bus.out_ready[m_ch];
        acc = bus.in_valid && m_in_ready();
        if (dlv) begin
            m_cnt  = m_cnt + 1'b1;
            m_ptr  = (m_ch + 1) % 4;
            m_held = 0;
        end
        if (acc) begin
            found = 0;
            for (int k = 0; k < 4; k++) begin
                if (!found && bus.en_mask[(m_ptr + k) % 4]) begin
                    m_ch  = (m_ptr + k) % 4;
                    found = 1;
                end
            end
            m_data = bus.in_data;
            m_held = 1;
        end
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 4'b0000 || bus.sel !== 2'b00 || bus.busy !== 1'b0 ||
            bus.sent_cnt !== '0 || bus.out_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b sel=%0d busy=%b cnt=%0d data=%h want 0s",
                     bus.out_valid, bus.sel, bus.busy, bus.sent_cnt, bus.out_data);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, 8'h00, 4'hF, 4'hF);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 4'b0000 || bus.sel !== 2'b00 ||
            bus.sent_cnt !== '0) begin
            errors++;
            $display("FAIL idle_after_reset: rdy=%b valid=%b sel=%0d cnt=%0d want 1/0000/0/0",
                     bus.in_ready, bus.out_valid, bus.sel, bus.sent_cnt);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] words [5] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        int         exp_sel [5] = '{0, 1, 2, 3, 0};
        for (int i = 0; i <= 5; i++) begin
            drive(i < 5, (i < 5) ? words[i] : 8'h00, 4'hF, 4'hF);
            if (i > 0) begin
                checks++;
                if (bus.sel !== 2'(exp_sel[i-1]) ||
                    bus.out_valid !== (4'b0001 << exp_sel[i-1]) ||
                    bus.out_data !== words[i-1]) begin
                    errors++;
                    $display("FAIL rr_word%0d: sel=%0d valid=%b data=%h want sel=%0d data=%h",
                             i - 1, bus.sel, bus.out_valid, bus.out_data, exp_sel[i-1],
                             words[i-1]);
                end
            end
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++; $display("FAIL rr_in_ready%0d: got %b want 1", i, bus.in_ready);
            end
            tick();
        end
        drive(1'b0, 8'h00, 4'hF, 4'hF);
        checks++;
        if (bus.sent_cnt !== CW'(5) || bus.out_valid !== 4'b0000) begin
            errors++;
            $display("FAIL rr_count: cnt=%0d valid=%b want 5/0000", bus.sent_cnt, bus.out_valid);
        end
    endtask

    task automatic test_masked_skip();
        logic [7:0] words [3] = '{8'h11, 8'h22, 8'h33};
        int         exp_ch [3] = '{1, 3, 1};
        for (int i = 0; i <= 3; i++) begin
            drive(i < 3, (i < 3) ? words[i] : 8'h00, 4'b1010, 4'hF);
            if (i > 0) begin
                checks++;
                if (bus.sel !== 2'(exp_ch[i-1]) || bus.out_data !== words[i-1]) begin
                    errors++;
                    $display("FAIL mask_word%0d: sel=%0d data=%h want sel=%0d data=%h",
                             i - 1, bus.sel, bus.out_data, exp_ch[i-1], words[i-1]);
                end
            end
            checks++;
            if ((bus.out_valid & 4'b0101) !== 4'b0000) begin
                errors++;
                $display("FAIL mask_disabled_valid: valid=%b want ch0/ch2 low", bus.out_valid);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [CW-1:0] cnt0;
        drive(1'b1, 8'h5C, 4'hF, 4'hF);
        tick();
        cnt0 = m_cnt;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'h66, 4'hF, 4'b1011);
            checks++;
            if (bus.out_valid !== 4'b0100 || bus.out_data !== 8'h5C || bus.in_ready !== 1'b0 ||
                bus.sent_cnt !== cnt0) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b data=%h rdy=%b cnt=%0d want 0100/5c/0/%0d",
                         i, bus.out_valid, bus.out_data, bus.in_ready, bus.sent_cnt, cnt0);
            end
            tick();
        end
        drive(1'b1, 8'h66, 4'hF, 4'hF);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release_ready: got %b want 1", bus.in_ready);
        end
        tick();
        drive(1'b0, 8'h00, 4'hF, 4'hF);
        checks++;
        if (bus.sent_cnt !== cnt0 + 1'b1 || bus.sel !== 2'd3 || bus.out_data !== 8'h66) begin
            errors++;
            $display("FAIL bp_release: cnt=%0d sel=%0d data=%h want %0d/3/66",
                     bus.sent_cnt, bus.sel, bus.out_data, cnt0 + 1'b1);
        end
        tick();
    endtask

    task automatic test_mask_edge();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'hEE, 4'b0000, 4'hF);
            checks++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 4'b0000) begin
                errors++;
                $display("FAIL mask_zero%0d: rdy=%b valid=%b want 0/0000",
                         i, bus.in_ready, bus.out_valid);
            end
            tick();
        end
        // Filler to channel 0 moves the pointer to 1
        drive(1'b1, 8'h70, 4'b0011, 4'hF);
        tick();
        drive(1'b1, 8'h77, 4'b0011, 4'hF);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 4'b0001, 4'b1101);
            checks++;
            if (bus.out_valid !== 4'b0010 || bus.sel !== 2'd1 || bus.out_data !== 8'h77) begin
                errors++;
                $display("FAIL mask_change_hold%0d: valid=%b sel=%0d data=%h want 0010/1/77",
                         i, bus.out_valid, bus.sel, bus.out_data);
            end
            tick();
        end
        drive(1'b1, 8'h78, 4'b0001, 4'hF);
        tick();
        drive(1'b0, 8'h00, 4'b0001, 4'hF);
        checks++;
        if (bus.sel !== 2'd0 || bus.out_data !== 8'h78 || bus.out_valid !== 4'b0001 ||
            bus.sent_cnt !== m_cnt) begin
            errors++;
            $display("FAIL mask_change_next: sel=%0d data=%h valid=%b cnt=%0d want 0/78/0001/%0d",
                     bus.sel, bus.out_data, bus.out_valid, bus.sent_cnt, m_cnt);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 8'h3D, 4'b1000, 4'h0);
        tick();
        drive(1'b0, 8'h00, 4'b1000, 4'h0);
        checks++;
        if (bus.out_valid !== 4'b1000) begin
            errors++; $display("FAIL rmid_setup: valid=%b want 1000", bus.out_valid);
        end
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (bus.out_valid !== 4'b0000 || bus.sent_cnt !== '0 || bus.sel !== 2'b00 ||
            bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rmid_async: valid=%b cnt=%0d sel=%0d busy=%b rdy=%b want all 0",
                     bus.out_valid, bus.sent_cnt, bus.sel, bus.busy, bus.in_ready);
        end
        #1;
        rst_n = 1'b1;
        drive(1'b1, 8'h99, 4'hF, 4'hF);
        tick();
        drive(1'b0, 8'h00, 4'hF, 4'hF);
        checks++;
        if (bus.sel !== 2'd0 || bus.out_valid !== 4'b0001 || bus.out_data !== 8'h99) begin
            errors++;
            $display("FAIL rmid_first: sel=%0d valid=%b data=%h want 0/0001/99",
                     bus.sel, bus.out_valid, bus.out_data);
        end
        tick();
    endtask

    task automatic test_random();
        logic [3:0] en;
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            drive($urandom_range(0, 9) < 7, 8'($urandom), en, 4'($urandom));
            checks++;
            if (bus.in_ready !== m_in_ready() || bus.out_valid !== m_valid() ||
                bus.sel !== 2'(m_ch) || bus.busy !== 1'(m_held) ||
                bus.out_data !== m_data || bus.sent_cnt !== m_cnt) begin
                errors++;
                $display("FAIL rand%0d: rdy=%b valid=%b sel=%0d busy=%b data=%h cnt=%0d want %b/%b/%0d/%b/%h/%0d",
                         i, bus.in_ready, bus.out_valid, bus.sel, bus.busy, bus.out_data,
                         bus.sent_cnt, m_in_ready(), m_valid(), m_ch, m_held, m_data, m_cnt);
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.en_mask   = 4'hF;
        bus.out_ready = 4'h0;
        model_reset();
        test_reset();
        test_round_robin();
        test_masked_skip();
        test_backpressure();
        test_mask_edge();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
